pingpong_fill_ctrl: RTL and testbench

- Write-side controller for the ECG ping-pong sample memory.
- Takes the acquired sample stream and produces the write address and write data (fu_addra, dt_an) for the bank currently in write mode.
- Owns the bank-select signal `switch`, which goes to the bank switching block.
- Toggles `switch` when a frame is full and the reader side has released the other bank, so acquisition and processing alternate between the two memories.

---
 rtl/pingpong_fill_ctrl.sv | 121 ++++++++++++
 tb/tb_pingpong_fill_ctrl.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pingpong_fill_ctrl.sv
// Write-side controller for the ECG ping-pong sample memory: fills the bank in
// write mode and flips the bank select once a frame is full and the reader is done.
//
// Handshake semantics: sample_valid and rd_done are single-cycle strobes with no
// back-pressure; the block never stalls its source. A sample it cannot store is
// parked in a one-entry pending register, and beyond that it is dropped and counted.
module pingpong_fill_ctrl #(
  parameter int DEPTH  = 4096,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sample_valid,
  input  logic [DATA_W-1:0] sample_in,
  input  logic              rd_done,
  output logic [ADDR_W-1:0] fu_addra,
  output logic [DATA_W-1:0] dt_an,
  output logic              switch,
  output logic              frame_ready,
  output logic              overrun,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FULL = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;
  logic              pend_vld;
  logic [DATA_W-1:0] pend_data;
  logic              rd_free;

  logic              wr_en;
  logic [DATA_W-1:0] wr_word;
  logic              last_word;
  logic              release_bank;
  logic              drop;

  always_comb begin
    wr_en        = 1'b0;
    wr_word      = sample_in;
    last_word    = (wr_ptr == ADDR_W'(DEPTH - 1));
    release_bank = 1'b0;
    drop         = 1'b0;
    // The pending entry is older than anything on sample_in, so it always goes first.
    if (pend_vld) wr_word = pend_data;
    case (state)
      FILL:    wr_en = pend_vld || sample_valid;
      FULL:    release_bank = rd_free || rd_done;
      WAIT:    release_bank = rd_done;
      default: wr_en = 1'b0;
    endcase
    // In FILL a full pending entry is always drained, so drops only occur while stalled.
    if (state != FILL) drop = sample_valid && pend_vld;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      wr_ptr      <= '0;
      pend_vld    <= 1'b0;
      pend_data   <= '0;
      rd_free     <= 1'b1;
      fu_addra    <= '0;
      dt_an       <= '0;
      switch      <= 1'b0;
      frame_ready <= 1'b0;
      overrun     <= 1'b0;
      drop_cnt    <= '0;
    end else begin
      frame_ready <= 1'b0;

      // Address and data move together; the memory rewrites the held word otherwise.
      if (wr_en) begin
        fu_addra <= wr_ptr;
        dt_an    <= wr_word;
        wr_ptr   <= last_word ? '0 : wr_ptr + ADDR_W'(1);
      end

      if (state == FILL) begin
        if (pend_vld) begin
          pend_vld <= sample_valid;
          if (sample_valid) pend_data <= sample_in;
        end
      end else if (sample_valid && !pend_vld) begin
        pend_vld  <= 1'b1;
        pend_data <= sample_in;
      end

      if (drop) begin
        overrun <= 1'b1;
        if (!(&drop_cnt)) drop_cnt <= drop_cnt + CNT_W'(1);
      end

      if (release_bank) begin
        switch      <= ~switch;
        frame_ready <= 1'b1;
      end

      // A bank flip hands the freshly filled bank to the reader, so it is busy again.
      if (release_bank) rd_free <= 1'b0;
      else if (rd_done) rd_free <= 1'b1;

      case (state)
        FILL:    if (wr_en && last_word) state <= FULL;
        FULL:    state <= release_bank ? FILL : WAIT;
        WAIT:    if (release_bank) state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_pingpong_fill_ctrl.sv
// Bench for pingpong_fill_ctrl: random sample streams checked against a
// queue-based frame model, one task per scenario.
module tb_pingpong_fill_ctrl;
  localparam int DEPTH    = 4096;
  localparam int ADDR_W   = 12;
  localparam int DATA_W   = 32;
  localparam int CNT_W    = 12;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              rst;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_in;
  logic              rd_done;
  logic [ADDR_W-1:0] fu_addra;
  logic [DATA_W-1:0] dt_an;
  logic              switch;
  logic              frame_ready;
  logic              overrun;
  logic [CNT_W-1:0]  drop_cnt;
  logic [1:0]        dbg_state;

  int checks = 0;
  int errors = 0;

  pingpong_fill_ctrl #(
    .DEPTH(DEPTH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .rst(rst), .sample_valid(sample_valid), .sample_in(sample_in),
    .rd_done(rd_done), .fu_addra(fu_addra), .dt_an(dt_an), .switch(switch),
    .frame_ready(frame_ready), .overrun(overrun), .drop_cnt(drop_cnt),
    .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  // Reference model: a frame is a count of words written, the pending slot is a
  // queue of at most one word, and a full frame waits until the reader is free.
  logic [DATA_W-1:0] pend_q[$];
  int                m_count;
  bit                m_frame_full;
  bit                m_reader_free;
  int                m_drops;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;
  bit                m_switch;
  bit                m_frame_ready;

  function automatic void model_reset();
    pend_q.delete();
    m_count = 0; m_frame_full = 0; m_reader_free = 1; m_drops = 0;
    m_addr = '0; m_data = '0; m_switch = 0; m_frame_ready = 0;
  endfunction

  function automatic logic [CNT_W-1:0] exp_drops();
    return (m_drops > DROP_MAX) ? CNT_W'(DROP_MAX) : CNT_W'(m_drops);
  endfunction

  function automatic void model_step(bit v, logic [DATA_W-1:0] d, bit rd);
    bit released = 0;
    bit wrote = 0;
    logic [DATA_W-1:0] w = '0;
    m_frame_ready = 0;
    if (!m_frame_full) begin
      if (pend_q.size() > 0) begin
        w = pend_q.pop_front();
        wrote = 1;
        if (v) pend_q.push_back(d);
      end else if (v) begin
        w = d;
        wrote = 1;
      end
      if (wrote) begin
        m_addr = ADDR_W'(m_count);
        m_data = w;
        m_count++;
        if (m_count == DEPTH) begin
          m_count = 0;
          m_frame_full = 1;
        end
      end
    end else begin
      if (v) begin
        if (pend_q.size() == 0) pend_q.push_back(d);
        else m_drops++;
      end
      if (rd || m_reader_free) begin
        m_switch = !m_switch;
        m_frame_ready = 1;
        m_frame_full = 0;
        released = 1;
      end
    end
    if (released) m_reader_free = 0;
    else if (rd) m_reader_free = 1;
  endfunction

  // driver tasks
  task automatic tick(input bit v, input logic [DATA_W-1:0] d, input bit rd);
    sample_valid = v;
    sample_in    = d;
    rd_done      = rd;
    @(posedge clk);
    model_step(v, d, rd);
    #1;
    sample_valid = 1'b0;
    rd_done      = 1'b0;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; sample_valid = 1'b0; sample_in = '0; rd_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    apply_reset();
    checks++; if (fu_addra !== '0) begin errors++; $display("FAIL reset_addr got %0h want 0", fu_addra); end
    checks++; if (dt_an !== '0) begin errors++; $display("FAIL reset_data got %0h want 0", dt_an); end
    checks++; if (switch !== 1'b0 || frame_ready !== 1'b0) begin errors++; $display("FAIL reset_switch got sw=%b fr=%b want 0 0", switch, frame_ready); end
    checks++; if (overrun !== 1'b0 || drop_cnt !== '0) begin errors++; $display("FAIL reset_overrun got ov=%b cnt=%0d want 0 0", overrun, drop_cnt); end
  endtask

  // One sample every 4 clocks, value = index, reader initially free.
  task automatic test_slow_frame();
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, DATA_W'(i), 1'b0);
      checks++;
      if (fu_addra !== ADDR_W'(i) || dt_an !== DATA_W'(i)) begin
        errors++; $display("FAIL slow_write idx %0d got addr=%0d data=%0d want %0d", i, fu_addra, dt_an, i);
      end
      if (i < DEPTH - 1) repeat (3) tick(1'b0, '0, 1'b0);
    end
    checks++; if (switch !== 1'b0) begin errors++; $display("FAIL slow_early_switch got %b want 0", switch); end
    tick(1'b0, '0, 1'b0);
    checks++; if (switch !== 1'b1 || frame_ready !== 1'b1) begin errors++; $display("FAIL slow_toggle got sw=%b fr=%b want 1 1", switch, frame_ready); end
    tick(1'b0, '0, 1'b0);
    checks++; if (frame_ready !== 1'b0 || switch !== 1'b1) begin errors++; $display("FAIL slow_after got sw=%b fr=%b want 1 0", switch, frame_ready); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL slow_overrun got %b want 0", overrun); end
  endtask

  // Reader withheld: frame parks in WAIT, one sample pends, two are dropped.
  task automatic test_wait_overrun();
    logic [DATA_W-1:0] p;
    for (int i = 0; i < DEPTH; i++) begin
      tick(1'b1, DATA_W'($urandom), 1'b0);
      checks++;
      if (fu_addra !== m_addr || dt_an !== m_data) begin
        errors++; $display("FAIL wait_fill idx %0d got %0d/%0h want %0d/%0h", i, fu_addra, dt_an, m_addr, m_data);
      end
    end
    repeat (2) tick(1'b0, '0, 1'b0);
    checks++; if (switch !== 1'b1 || frame_ready !== 1'b0) begin errors++; $display("FAIL wait_hold got sw=%b fr=%b want 1 0", switch, frame_ready); end
    p = DATA_W'($urandom);
    tick(1'b1, p, 1'b0);
    checks++; if (drop_cnt !== '0) begin errors++; $display("FAIL wait_pend_nodrop got %0d want 0", drop_cnt); end
    repeat (2) tick(1'b1, DATA_W'($urandom), 1'b0);
    checks++; if (drop_cnt !== CNT_W'(2) || overrun !== 1'b1) begin errors++; $display("FAIL wait_drops got cnt=%0d ov=%b want 2 1", drop_cnt, overrun); end
    checks++; if (fu_addra !== ADDR_W'(DEPTH - 1)) begin errors++; $display("FAIL wait_addr_hold got %0d want %0d", fu_addra, DEPTH - 1); end
    tick(1'b0, '0, 1'b1);
    checks++; if (switch !== 1'b0 || frame_ready !== 1'b1) begin errors++; $display("FAIL wait_release got sw=%b fr=%b want 0 1", switch, frame_ready); end
    tick(1'b0, '0, 1'b0);
    checks++; if (fu_addra !== '0 || dt_an !== p) begin errors++; $display("FAIL wait_pend_write got %0d/%0h want 0/%0h", fu_addra, dt_an, p); end
  endtask

  // rd_done lands exactly in the FULL cycle while the reader was busy.
  task automatic test_rd_done_in_full();
    int guard = 0;
    while (!m_frame_full && guard < DEPTH + 8) begin
      tick(1'b1, DATA_W'($urandom), 1'b0);
      guard++;
    end
    checks++; if (fu_addra !== ADDR_W'(DEPTH - 1) || dt_an !== m_data) begin errors++; $display("FAIL full_last got %0d/%0h want %0d/%0h", fu_addra, dt_an, DEPTH - 1, m_data); end
    tick(1'b0, '0, 1'b1);
    checks++; if (switch !== 1'b1 || frame_ready !== 1'b1) begin errors++; $display("FAIL full_rd_done got sw=%b fr=%b want 1 1", switch, frame_ready); end
    tick(1'b0, '0, 1'b0);
    checks++; if (switch !== 1'b1 || frame_ready !== 1'b0) begin errors++; $display("FAIL full_after got sw=%b fr=%b want 1 0", switch, frame_ready); end
  endtask

  // Samples every clock across a frame boundary with the reader already free.
  task automatic test_back_to_back();
    logic [DATA_W-1:0] b;
    int guard = 0;
    tick(1'b1, DATA_W'($urandom), 1'b1);
    while (!m_frame_full && guard < DEPTH + 8) begin
      tick(1'b1, DATA_W'($urandom), 1'b0);
      checks++;
      if (fu_addra !== m_addr || dt_an !== m_data) begin
        errors++; $display("FAIL b2b_fill got %0d/%0h want %0d/%0h", fu_addra, dt_an, m_addr, m_data);
      end
      guard++;
    end
    b = DATA_W'($urandom);
    tick(1'b1, b, 1'b0);
    checks++; if (switch !== 1'b0 || frame_ready !== 1'b1) begin errors++; $display("FAIL b2b_toggle got sw=%b fr=%b want 0 1", switch, frame_ready); end
    tick(1'b1, DATA_W'($urandom), 1'b0);
    checks++; if (fu_addra !== '0 || dt_an !== b) begin errors++; $display("FAIL b2b_first got %0d/%0h want 0/%0h", fu_addra, dt_an, b); end
    checks++; if (drop_cnt !== exp_drops()) begin errors++; $display("FAIL b2b_drops got %0d want %0d", drop_cnt, exp_drops()); end
  endtask

  // Keep streaming to wr_ptr=1000 with the pending slot occupied, then reset mid-frame.
  task automatic test_async_reset();
    logic [DATA_W-1:0] d;
    while (m_count < 1000) begin
      tick(1'b1, DATA_W'($urandom), 1'b0);
      checks++;
      if (fu_addra !== m_addr || dt_an !== m_data) begin
        errors++; $display("FAIL rst_fill got %0d/%0h want %0d/%0h", fu_addra, dt_an, m_addr, m_data);
      end
    end
    #2 rst = 1'b1;
    #1;
    checks++; if (fu_addra !== '0 || dt_an !== '0) begin errors++; $display("FAIL rst_async_addr got %0d/%0h want 0/0", fu_addra, dt_an); end
    checks++; if (switch !== 1'b0 || frame_ready !== 1'b0) begin errors++; $display("FAIL rst_async_switch got sw=%b fr=%b want 0 0", switch, frame_ready); end
    checks++; if (overrun !== 1'b0 || drop_cnt !== '0) begin errors++; $display("FAIL rst_async_drops got ov=%b cnt=%0d want 0 0", overrun, drop_cnt); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    d = DATA_W'($urandom);
    tick(1'b1, d, 1'b0);
    checks++; if (fu_addra !== '0 || dt_an !== d || switch !== 1'b0) begin errors++; $display("FAIL rst_first got %0d/%0h sw=%b want 0/%0h sw=0", fu_addra, dt_an, switch, d); end
  endtask

  // Two frames to reach WAIT, then enough extra samples to saturate drop_cnt.
  task automatic test_drop_saturation();
    logic [DATA_W-1:0] s0;
    int guard = 0;
    while (!m_frame_full && guard < DEPTH + 8) begin tick(1'b1, DATA_W'($urandom), 1'b0); guard++; end
    tick(1'b0, '0, 1'b0);
    checks++; if (switch !== 1'b1) begin errors++; $display("FAIL sat_first_toggle got %b want 1", switch); end
    guard = 0;
    while (!m_frame_full && guard < DEPTH + 8) begin tick(1'b1, DATA_W'($urandom), 1'b0); guard++; end
    s0 = DATA_W'($urandom);
    tick(1'b1, s0, 1'b0);
    for (int k = 1; k <= (1 << CNT_W) + 5; k++) begin
      tick(1'b1, DATA_W'($urandom), 1'b0);
      if (k == DROP_MAX - 1) begin
        checks++; if (drop_cnt !== CNT_W'(DROP_MAX - 1)) begin errors++; $display("FAIL sat_pre got %0d want %0d", drop_cnt, DROP_MAX - 1); end
      end
    end
    checks++; if (drop_cnt !== CNT_W'(DROP_MAX) || drop_cnt !== exp_drops()) begin errors++; $display("FAIL sat_final got %0d want %0d", drop_cnt, DROP_MAX); end
    checks++; if (overrun !== 1'b1 || switch !== 1'b1) begin errors++; $display("FAIL sat_flags got ov=%b sw=%b want 1 1", overrun, switch); end
    tick(1'b0, '0, 1'b1);
    tick(1'b0, '0, 1'b0);
    checks++; if (switch !== 1'b0 || fu_addra !== '0 || dt_an !== s0) begin errors++; $display("FAIL sat_release got sw=%b %0d/%0h want 0 0/%0h", switch, fu_addra, dt_an, s0); end
  endtask

  initial begin
    test_reset();
    test_slow_frame();
    test_wait_overrun();
    test_rd_done_in_full();
    test_back_to_back();
    test_async_reset();
    test_drop_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
